call_return_ctrl: RTL
=====================

Name: call_return_ctrl

Overview:
- Initiator/driver for the processor's LIFO stack block; owns the stack's c/en/push inputs and consumes its peek/full/not_empty outputs.
- Turns single-cycle CALL (save return address) and RET (restore return address) requests from the control unit into correctly sequenced stack operations.
- Sequencing includes the mandatory peek-refresh idle cycle after each stack operation.
- Sits between the control unit/PC logic and the stack.

Parameters:
- WIDTH, 8, address/data width; matches the stack's width.
- DEPTH, 1, stack pointer width; matches the stack's depth; sizes the shadow occupancy counter.

Ports:
- clk  in  1  system clock, rising edge.
- clr  in  1  asynchronous, active-low reset.
- call_req  in  1  request to push call_addr.
- ret_req  in  1  request to pop the return address.
- call_addr  in  WIDTH  return address to save.
- req_ready  out  1  high when a request will be accepted at the next edge.
- ret_valid  out  1  one-cycle pulse: ret_addr valid.
- ret_addr  out  WIDTH  restored return address.
- err  out  1  one-cycle pulse: request rejected.
- depth_cnt  out  DEPTH+1  shadow count of entries pushed by this block.
- trap  out  1  sticky error; only active with the optional feature.
- trap_clr  in  1  clears trap; only active with the optional feature.
- stk_c  out  1  to stack c: 1 = push, 0 = pop.
- stk_en  out  1  to stack en: 1 = operate, 0 = refresh peek.
- stk_push  out  WIDTH  to stack push.
- stk_peek  in  WIDTH  from stack peek.
- stk_full  in  1  from stack full.
- stk_not_empty  in  1  from stack not_empty.

Behaviour:
- Reset (clr low, async, takes effect immediately):
  - State IDLE; stk_en=0, stk_c=0, stk_push=0.
  - ret_valid=0, ret_addr=0, err=0, trap=0, depth_cnt=0.
  - req_ready=1 once clr is released.
  - The stack's own clr is driven by system reset logic, not by this block; the system asserts both together.
- Reset mid-operation abandons the operation; the stack is assumed cleared in the same reset.
- FSM states:
  - IDLE: req_ready=1, stk_en=0.
  - PUSH: stk_en=1, stk_c=1, stk_push=latched address.
  - POP: stk_en=1, stk_c=0.
  - SETTLE: stk_en=0; one cycle so the stack refreshes peek.
  - TRAP: optional feature only.
- Acceptance: a request is accepted on a rising edge in IDLE with call_req or ret_req high. All other states ignore requests; no queuing.
- Priority: call_req and ret_req both high -> CALL wins; RET is dropped silently and must be re-presented.
- CALL accepted, stk_full=0:
  - Latch call_addr; go to PUSH; depth_cnt+1 at that edge.
  - PUSH -> SETTLE -> IDLE.
  - req_ready low for 2 cycles; a new request can be accepted on the 3rd edge after acceptance.
- RET accepted, stk_not_empty=1:
  - At the acceptance edge, ret_addr <= stk_peek. Peek is valid because stk_en was 0 in IDLE. The stack's pop updates peek to the new top, so the value must be captured before popping.
  - Go to POP; ret_valid=1 during the POP cycle only; depth_cnt-1.
  - POP -> SETTLE -> IDLE.
- CALL with stk_full=1, or RET with stk_not_empty=0:
  - No stack operation (stk_en stays 0); err=1 for the next cycle; state stays IDLE; depth_cnt unchanged.
- Stack flags are authoritative.
- depth_cnt is informational and wraps modulo 2^(DEPTH+1); it is never used for gating.
- stk_push holds its last value outside PUSH; ret_addr holds until the next accepted RET.

Optional Feature:
- Macro: STACK_TRAP_EN.
- Defined:
  - A rejected request asserts err for one cycle, sets trap=1, and enters TRAP.
  - In TRAP: req_ready=0, stk_en=0.
  - trap_clr high at an edge -> trap=0, state IDLE.
  - Reset also clears trap.
- Undefined:
  - No TRAP state; trap tied 0; trap_clr ignored.
  - Rejected requests only pulse err.

Test Plan:
- Reset: drive clr low mid-PUSH -> stk_en=0 immediately; all outputs 0; after release req_ready=1 and depth_cnt=0.
- CALL, call_addr=0x3C, stk_full=0:
  - Cycle+1: stk_en=1, stk_c=1, stk_push=0x3C.
  - Cycle+2: stk_en=0.
  - req_ready=1 at cycle+3; depth_cnt=1.
- RET, stk_peek=0x3C, stk_not_empty=1 -> next cycle: ret_valid=1, ret_addr=0x3C, stk_en=1, stk_c=0; then SETTLE; depth_cnt=0.
- RET with stk_not_empty=0 -> err pulse for exactly 1 cycle; stk_en never 1; req_ready stays 1.
- call_req=ret_req=1 with call_addr=0x55 -> only a push of 0x55; no ret_valid; no err.
- With STACK_TRAP_EN, CALL while stk_full=1:
  - err pulse; trap=1; req_ready=0; further requests ignored.
  - trap_clr pulse -> trap=0, req_ready=1.

Source files
------------

// File: rtl/call_return_ctrl.sv
// call_return_ctrl: turns single-cycle CALL/RET requests from the control unit into
// sequenced operations on the LIFO return-address stack.
//
// Every stack operation (PUSH or POP) is followed by one SETTLE cycle with stk_en_o low,
// so the stack can refresh its peek output before the next request is accepted.
//
// Optional feature: define STACK_TRAP_EN to make a rejected request enter a sticky TRAP
// state that only trap_clr_i (or reset) leaves. Without it, rejects only pulse err_o.
//
// Ports:
//   clk_i          system clock, rising edge
//   clr_ni         asynchronous active-low reset
//   call_req_i     push call_addr_i (wins over ret_req_i)
//   ret_req_i      pop the return address
//   call_addr_i    return address to save
//   req_ready_o    a request will be accepted at the next edge
//   ret_valid_o    one-cycle pulse, ret_addr_o valid
//   ret_addr_o     restored return address (held until the next accepted RET)
//   err_o          one-cycle pulse, request rejected
//   depth_cnt_o    shadow count of entries pushed (informational, wraps)
//   trap_o         sticky error (STACK_TRAP_EN only, else 0)
//   trap_clr_i     clears trap (STACK_TRAP_EN only)
//   stk_c_o        stack c: 1 = push, 0 = pop
//   stk_en_o       stack en: 1 = operate, 0 = refresh peek
//   stk_push_o     stack push data
//   stk_peek_i     stack top of stack
//   stk_full_i     stack full flag
//   stk_not_empty_i stack not-empty flag
module call_return_ctrl #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 1
) (
  input  logic             clk_i,
  input  logic             clr_ni,
  input  logic             call_req_i,
  input  logic             ret_req_i,
  input  logic [Width-1:0] call_addr_i,
  output logic             req_ready_o,
  output logic             ret_valid_o,
  output logic [Width-1:0] ret_addr_o,
  output logic             err_o,
  output logic [Depth:0]   depth_cnt_o,
  output logic             trap_o,
  input  logic             trap_clr_i,
  output logic             stk_c_o,
  output logic             stk_en_o,
  output logic [Width-1:0] stk_push_o,
  input  logic [Width-1:0] stk_peek_i,
  input  logic             stk_full_i,
  input  logic             stk_not_empty_i
);

  typedef enum logic [2:0] {
    StIdle,
    StPush,
    StPop,
    StSettle
`ifdef STACK_TRAP_EN
    , StTrap
`endif
  } state_e;

  localparam logic [Depth:0] DepthOne = 1;

  state_e             state_q, state_d;
  logic [Width-1:0]   push_q, push_d;
  logic [Width-1:0]   ret_addr_q, ret_addr_d;
  logic [Depth:0]     depth_q, depth_d;
  logic               err_q, err_d;
  logic               reject;

  always_comb begin
    state_d    = state_q;
    push_d     = push_q;
    ret_addr_d = ret_addr_q;
    depth_d    = depth_q;
    err_d      = 1'b0;
    reject     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (call_req_i) begin
          if (!stk_full_i) begin
            push_d  = call_addr_i;
            depth_d = depth_q + DepthOne;
            state_d = StPush;
          end else begin
            reject = 1'b1;
          end
        end else if (ret_req_i) begin
          if (stk_not_empty_i) begin
            // Capture peek now: the pop will replace it with the next entry.
            ret_addr_d = stk_peek_i;
            depth_d    = depth_q - DepthOne;
            state_d    = StPop;
          end else begin
            reject = 1'b1;
          end
        end
      end
      StPush, StPop: state_d = StSettle;
      StSettle:      state_d = StIdle;
`ifdef STACK_TRAP_EN
      StTrap: begin
        if (trap_clr_i) begin
          state_d = StIdle;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
    if (reject) begin
      err_d = 1'b1;
`ifdef STACK_TRAP_EN
      state_d = StTrap;
`endif
    end
  end

  always_ff @(posedge clk_i or negedge clr_ni) begin
    if (!clr_ni) begin
      state_q    <= StIdle;
      push_q     <= '0;
      ret_addr_q <= '0;
      depth_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      push_q     <= push_d;
      ret_addr_q <= ret_addr_d;
      depth_q    <= depth_d;
      err_q      <= err_d;
    end
  end

`ifdef STACK_TRAP_EN
  logic trap_q, trap_d;

  always_comb begin
    trap_d = trap_q;
    if (reject) begin
      trap_d = 1'b1;
    end else if (state_q == StTrap && trap_clr_i) begin
      trap_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge clr_ni) begin
    if (!clr_ni) begin
      trap_q <= 1'b0;
    end else begin
      trap_q <= trap_d;
    end
  end

  assign trap_o = trap_q;
`else
  logic unused_trap_clr;
  assign unused_trap_clr = trap_clr_i;
  assign trap_o          = 1'b0;
`endif

  assign req_ready_o = (state_q == StIdle);
  assign stk_en_o    = (state_q == StPush) || (state_q == StPop);
  assign stk_c_o     = (state_q == StPush);
  assign stk_push_o  = push_q;
  assign ret_valid_o = (state_q == StPop);
  assign ret_addr_o  = ret_addr_q;
  assign err_o       = err_q;
  assign depth_cnt_o = depth_q;

endmodule
